seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Observes a multiplexed, active-low 7-segment display bus (anodes + segments a..g) and recovers
//  the hex digit shown on each position. Segment code map matches the team's display encoding
//  (0=0000001 ... F=0111000, {a..g}, 0=lit). Used as a display snooper/self-check next to the scan
//  driver and as a bench monitor on board bring-up.
// PARAMETERS
//  NUM_DIGITS     8   number of anode positions observed
//  STABLE_CYCLES  16  consecutive identical synchronized samples required before capture (>=2)
//  CNT_W          5   stability counter width; must hold STABLE_CYCLES
// PORTS
//  clk          in   1             system clock; single clock domain
//  reset_n      in   1             asynchronous, active-low reset
//  an           in   NUM_DIGITS    anode enables, active low, asynchronous to clk
//  seg          in   7             {a,b,c,d,e,f,g}, active low, asynchronous to clk
//  hex_out      out  4*NUM_DIGITS  digit i at [4i+3:4i]
//  digit_valid  out  NUM_DIGITS    bit i = last capture on digit i was a legal hex pattern
//  frame_done   out  1             1-cycle pulse: every digit captured legally since last pulse
//  bad_pattern  out  1             1-cycle pulse: capture saw a non-hex, non-blank pattern
//  bad_digit    out  3             index of digit for last bad_pattern (held until next one)
//  err_count    out  8             only with SEG7_CAP_ERRCNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync-released use): hex_out=0, digit_valid=0, frame_done=0, bad_pattern=0,
//    bad_digit=0, seen mask=0, counter=0, FSM=UNSTABLE. Reset mid-settle discards partial capture.
//  - an/seg pass a 2-flop synchronizer; all rules below apply to the synchronized vector s={an,seg}.
//  - FSM: UNSTABLE -> SETTLING when s equals its previous-cycle value; SETTLING -> UNSTABLE on any
//    change (counter cleared); SETTLING -> HELD when counter reaches STABLE_CYCLES-1 (capture edge);
//    HELD -> UNSTABLE on any change of s. Exactly one capture per stable window.
//  - Capture: requires exactly one an bit low. Zero or >1 anodes low: no update, no error.
//    Legal pattern: hex_out digit <= decoded value, digit_valid[i]<=1, seen[i]<=1.
//    Blank 1111111: digit_valid[i]<=0, hex_out digit held, no error.
//    Other: bad_pattern pulses, bad_digit<=i, digit_valid[i]<=0, hex_out digit held.
//  - All outputs registered; updates appear the edge after the capture edge.
//  - frame_done pulses the cycle after the capture that makes seen all-ones; seen clears to 0 on that
//    same edge (the completing capture is not carried into the next frame).
//  - Latency from pin change to hex_out: 2 (sync) + STABLE_CYCLES + 1 cycles, +-1 for async sampling.
//  - Digit re-shown with same value: re-captured, digit_valid stays 1, no spurious pulses.
// CONFIGURATION
//  SEG7_CAP_ERRCNT_EN defined: err_count port present; increments on each bad_pattern, saturates at
//  255, reset to 0. Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  seg7_pkg: SEG_0..SEG_F, SEG_BLANK 7-bit constants, default parameter values, FSM state encoding.
//  Sub-module seg7_to_hex: combinational inverse decoder seg[6:0] -> {hex[3:0], legal, blank}.
//  Top holds synchronizer, stability counter/FSM, anode one-hot check, digit registers, frame mask.
// TESTING
//  1 an=11111110, seg=0000110 held 30 cycles -> hex_out[3:0]=3, digit_valid=0x01, no bad_pattern.
//  2 scan digits 0..7 showing 0,1,2,...,7 (25 cycles each) -> hex_out=0x76543210, valid=0xFF,
//    one frame_done pulse after digit 7 capture; repeat scan -> second pulse, seen cleared between.
//  3 an=11110111, seg=1111110 for 30 cycles -> bad_pattern 1 pulse, bad_digit=3, valid[3]=0,
//    digit 3 value unchanged; with SEG7_CAP_ERRCNT_EN err_count=1.
//  4 segment toggling every 8 cycles (< STABLE_CYCLES) for 200 cycles -> no capture, outputs frozen;
//    an=11111100 stable 30 cycles -> no capture, no error.
//  5 reset_n low for 1 cycle mid-settle after valid data -> all outputs 0 immediately, FSM UNSTABLE;
//    then digit 5 showing B (1100000) 30 cycles -> hex_out[23:20]=B, valid=0x20.
//  6 with errcnt enabled, 300 bad captures -> err_count=255 (saturated, no wrap).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block: active-low {a..g} segment codes,
// default parameter values and the stability FSM state encoding.
package seg7_pkg;

  localparam int DEF_NUM_DIGITS    = 8;
  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_CNT_W         = 5;

  // Segment order {a,b,c,d,e,f,g}; a 0 bit means the segment is lit.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_UNSTABLE = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment decoder: maps an active-low {a..g} pattern back to its hex value,
// flagging whether it is a legal hex glyph or the all-dark blank pattern.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_hex,
  output logic       o_legal,
  output logic       o_blank
);

  always_comb begin
    o_hex   = 4'h0;
    o_legal = 1'b1;
    o_blank = 1'b0;
    case (i_seg)
      SEG_0:     o_hex = 4'h0;
      SEG_1:     o_hex = 4'h1;
      SEG_2:     o_hex = 4'h2;
      SEG_3:     o_hex = 4'h3;
      SEG_4:     o_hex = 4'h4;
      SEG_5:     o_hex = 4'h5;
      SEG_6:     o_hex = 4'h6;
      SEG_7:     o_hex = 4'h7;
      SEG_8:     o_hex = 4'h8;
      SEG_9:     o_hex = 4'h9;
      SEG_A:     o_hex = 4'hA;
      SEG_B:     o_hex = 4'hB;
      SEG_C:     o_hex = 4'hC;
      SEG_D:     o_hex = 4'hD;
      SEG_E:     o_hex = 4'hE;
      SEG_F:     o_hex = 4'hF;
      SEG_BLANK: begin
        o_legal = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the digit on each anode.
// Define SEG7_CAP_ERRCNT_EN to add the saturating err_count output.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    bad_pattern,
  output logic [2:0]              bad_digit
`ifdef SEG7_CAP_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int SW = NUM_DIGITS + 7;

  logic [SW-1:0]           r_sync_p0;
  logic [SW-1:0]           r_sync_p1;
  logic [SW-1:0]           r_prev;
  cap_state_t              r_state;
  cap_state_t              w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_capture;
  logic                    w_change;
  logic [NUM_DIGITS-1:0]   w_an_low;
  logic                    w_one_hot;
  logic [2:0]              w_idx;
  logic [6:0]              w_seg;
  logic [3:0]              w_hex;
  logic                    w_legal;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic                    r_frame_done;
  logic                    r_bad;
  logic [2:0]              r_bad_digit;
`ifdef SEG7_CAP_ERRCNT_EN
  logic [7:0]              r_err_cnt;
`endif

  // Stage p0/p1: two-flop synchronizer; idle value is all-dark with no anode enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_prev    <= '1;
    end else begin
      r_sync_p0 <= {an, seg};
      r_sync_p1 <= r_sync_p0;
      r_prev    <= r_sync_p1;
    end
  end

  assign w_change = (r_sync_p1 != r_prev);
  assign w_an_low = ~r_sync_p1[SW-1:7];
  assign w_seg    = r_sync_p1[6:0];
  assign w_one_hot = (w_an_low != '0) &&
                     ((w_an_low & (w_an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_low[i]) w_idx = 3'(i);
    end
  end

  seg7_to_hex u_dec (
    .i_seg   (w_seg),
    .o_hex   (w_hex),
    .o_legal (w_legal),
    .o_blank (w_blank)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_UNSTABLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter only runs while settling; any disturbance restarts the window from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_capture   = 1'b0;
    case (r_state)
      ST_UNSTABLE: begin
        if (!w_change) w_state_nxt = ST_SETTLING;
      end
      ST_SETTLING: begin
        if (w_change) begin
          w_state_nxt = ST_UNSTABLE;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_nxt = ST_HELD;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (w_change) w_state_nxt = ST_UNSTABLE;
      end
      default: w_state_nxt = ST_UNSTABLE;
    endcase
  end

  assign w_seen_nxt = r_seen | w_an_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex        <= '0;
      r_valid      <= '0;
      r_seen       <= '0;
      r_frame_done <= 1'b0;
      r_bad        <= 1'b0;
      r_bad_digit  <= 3'd0;
`ifdef SEG7_CAP_ERRCNT_EN
      r_err_cnt    <= 8'd0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      r_bad        <= 1'b0;
      if (w_capture && w_one_hot) begin
        if (w_legal) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_an_low[i]) r_hex[4*i +: 4] <= w_hex;
          end
          r_valid <= r_valid | w_an_low;
          // The completing capture starts a fresh frame rather than counting toward the next one.
          if (w_seen_nxt == '1) begin
            r_frame_done <= 1'b1;
            r_seen       <= '0;
          end else begin
            r_seen <= w_seen_nxt;
          end
        end else if (w_blank) begin
          r_valid <= r_valid & ~w_an_low;
        end else begin
          r_valid     <= r_valid & ~w_an_low;
          r_bad       <= 1'b1;
          r_bad_digit <= w_idx;
`ifdef SEG7_CAP_ERRCNT_EN
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`endif
        end
      end
    end
  end

  assign hex_out     = r_hex;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign bad_pattern = r_bad;
  assign bad_digit   = r_bad_digit;
`ifdef SEG7_CAP_ERRCNT_EN
  assign err_count   = r_err_cnt;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: scoreboard of expected digit state against a
// behavioural model of the capture rules, with pulse counters on frame_done/bad_pattern.
module tb_seg7_capture;

  logic        clk;
  logic        reset_n;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] hex_out;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        bad_pattern;
  logic [2:0]  bad_digit;
`ifdef SEG7_CAP_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  seg7_capture dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .an          (an),
    .seg         (seg),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .bad_pattern (bad_pattern),
    .bad_digit   (bad_digit)
`ifdef SEG7_CAP_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [31:0] hex;
    logic [7:0]  valid;
    int          frames;
    int          bads;
    logic [2:0]  bdig;
    int          errs;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hex;
  logic [7:0]  m_valid;
  logic [7:0]  m_seen;
  int          m_frames;
  int          m_bads;
  logic [2:0]  m_bdig;
  int          m_errs;

  int mon_frames = 0;
  int mon_bads   = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) mon_frames++;
    if (bad_pattern === 1'b1) mon_bads++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_hex = '0; m_valid = '0; m_seen = '0; m_bdig = '0; m_errs = 0;
  endtask

  task automatic model_capture(input logic [7:0] a, input logic [6:0] s);
    logic [7:0] al;
    int idx;
    int val;
    al = ~a;
    if ($countones(al) != 1) return;
    idx = 0;
    for (int i = 0; i < 8; i++) if (al[i]) idx = i;
    val = -1;
    for (int k = 0; k < 16; k++) if (GLYPH[k] == s) val = k;
    if (val >= 0) begin
      m_hex[4*idx +: 4] = 4'(val);
      m_valid[idx] = 1'b1;
      m_seen[idx] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_frames++;
        m_seen = '0;
      end
    end else if (s == 7'b1111111) begin
      m_valid[idx] = 1'b0;
    end else begin
      m_valid[idx] = 1'b0;
      m_bads++;
      m_bdig = 3'(idx);
      if (m_errs < 255) m_errs++;
    end
  endtask

  // Drive a pattern for n cycles; long holds are captured, short ones must not be.
  task automatic show(input logic [7:0] a, input logic [6:0] s, input int n,
                      input bit do_chk, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    an  = a;
    seg = s;
    if (n >= 24) model_capture(a, s);
    if (do_chk) begin
      e.hex = m_hex; e.valid = m_valid; e.frames = m_frames;
      e.bads = m_bads; e.bdig = m_bdig; e.errs = m_errs;
      sb.push_back(e);
    end
    repeat (n) @(negedge clk);
    if (do_chk) begin
      got = sb.pop_front();
      chk({tag, "_hex"},    64'(hex_out),     64'(got.hex));
      chk({tag, "_valid"},  64'(digit_valid), 64'(got.valid));
      chk({tag, "_frames"}, 64'(mon_frames),  64'(got.frames));
      chk({tag, "_bads"},   64'(mon_bads),    64'(got.bads));
      chk({tag, "_bdig"},   64'(bad_digit),   64'(got.bdig));
`ifdef SEG7_CAP_ERRCNT_EN
      chk({tag, "_errcnt"}, 64'(err_count),   64'(got.errs));
`endif
    end
  endtask

  initial begin
    reset_n = 1'b0;
    an  = 8'hFF;
    seg = 7'h7F;
    m_frames = 0;
    m_bads   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hex",   64'(hex_out),     64'h0);
    chk("rst_valid", 64'(digit_valid), 64'h0);
    chk("rst_frame", 64'(frame_done),  64'h0);
    chk("rst_bad",   64'(bad_pattern), 64'h0);
    chk("rst_bdig",  64'(bad_digit),   64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single digit 0 showing 3.
    show(8'hFE, 7'b0000110, 30, 1'b1, "t1");

    // Two full scans 0..7; each completes a frame.
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 8; d++) begin
        show(~(8'h01 << d), GLYPH[d], 25, d == 7, r == 0 ? "t2_scan1" : "t2_scan2");
      end
    end

    // Non-hex pattern on digit 3.
    show(8'hF7, 7'b1111110, 30, 1'b1, "t3");

    // Flicker faster than the stability window, then two anodes at once.
    for (int k = 0; k < 25; k++) begin
      show(8'hFE, (k % 2) ? GLYPH[7] : GLYPH[1], 8, 1'b0, "t4_tog");
    end
    show(8'hFC, GLYPH[8], 30, 1'b1, "t4");

    // Blank on digit 1 clears its valid bit but keeps its value.
    show(8'hFD, 7'b1111111, 30, 1'b1, "t4_blank");

    // Reset in the middle of a settle window.
    show(8'hBF, GLYPH[4], 8, 1'b0, "t5_pre");
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_hex",   64'(hex_out),     64'h0);
    chk("t5_rst_valid", 64'(digit_valid), 64'h0);
    chk("t5_rst_frame", 64'(frame_done),  64'h0);
    chk("t5_rst_bad",   64'(bad_pattern), 64'h0);
    chk("t5_rst_bdig",  64'(bad_digit),   64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    show(8'hDF, 7'b1100000, 30, 1'b1, "t5");

`ifdef SEG7_CAP_ERRCNT_EN
    // Saturation: alternate two illegal patterns so every hold is a fresh capture.
    for (int k = 0; k < 300; k++) begin
      show((k % 2) ? 8'hF7 : 8'hFB, (k % 2) ? 7'b1111110 : 7'b1111101, 24,
           k == 299, "t6");
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
